// File: rtl/mdio_master_if.sv
// Management-side request/response bus of the Clause-22 MDIO master.
interface mdio_master_if;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;

    logic              i_req;
    logic              i_wr;
    logic [ADDR_W-1:0] i_phy_addr;
    logic [ADDR_W-1:0] i_reg_addr;
    logic [DATA_W-1:0] i_wdata;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_rdata;
    logic              o_rd_err;

    // Requester (CPU bridge) side
    modport master (
        output i_req, i_wr, i_phy_addr, i_reg_addr, i_wdata,
        input  o_busy, o_done, o_rdata, o_rd_err
    );

    // MDIO master side
    modport slave (
        input  i_req, i_wr, i_phy_addr, i_reg_addr, i_wdata,
        output o_busy, o_done, o_rdata, o_rd_err
    );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: serialises PHY register read/write frames
// onto MDC/MDO/MDO_T and captures read data from MDI.
module mdio_master #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mdio_master_if.slave mgmt,
    output logic         o_mdc,
    output logic         o_mdo,
    output logic         o_mdo_t,
    input  logic         i_mdi
);
    localparam int unsigned NBITS   = PREAMBLE_LEN + 32;
    localparam int unsigned FRAME_W = 64;
    localparam int unsigned DIV_W   = $clog2(2 * CLK_DIV);
    localparam int unsigned CNT_W   = $clog2(NBITS + 1);

    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    // Bits still to start when the first TA bit begins; read releases the line from there on
    localparam logic [CNT_W-1:0] CNT_TA1_START = CNT_W'(18);
    // Bits remaining after the current one: 2nd TA bit and the 16 data bits
    localparam logic [CNT_W-1:0] CNT_TA2  = CNT_W'(16);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(16);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_W-1:0] frame_q;
    logic               is_rd_q;
    logic [15:0]        rsh_q;
    logic               err_q;
    logic               busy_q;
    logic               done_q;
    logic [15:0]        rdata_q;
    logic               rd_err_q;
    logic               mdc_q;
    logic               mdo_q;
    logic               mdo_t_q;

    logic [1:0]         op_bits;
    logic [17:0]        tail_bits;
    logic [FRAME_W-1:0] frame_init;

    // Frame image, MSB first; read TA/data slots are 1s so MDO idles high while released
    assign op_bits    = mgmt.i_wr ? 2'b01 : 2'b10;
    assign tail_bits  = mgmt.i_wr ? {2'b10, mgmt.i_wdata} : 18'h3_FFFF;
    assign frame_init = {32'hFFFF_FFFF, 2'b01, op_bits, mgmt.i_phy_addr,
                         mgmt.i_reg_addr, tail_bits};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            frame_q  <= '0;
            is_rd_q  <= 1'b0;
            rsh_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            rd_err_q <= 1'b0;
            mdc_q    <= 1'b0;
            mdo_q    <= 1'b1;
            mdo_t_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mgmt.i_req) begin
                        state_q <= ST_SHIFT;
                        busy_q  <= 1'b1;
                        frame_q <= frame_init;
                        is_rd_q <= ~mgmt.i_wr;
                        cnt_q   <= CNT_W'(NBITS);
                        // First SHIFT cycle is a bit boundary, so bit 0 starts immediately
                        div_q   <= DIV_LAST;
                        err_q   <= 1'b0;
                        rsh_q   <= '0;
                    end
                end

                ST_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        mdc_q <= 1'b0;
                        if (cnt_q == '0) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            mdo_q   <= 1'b1;
                            mdo_t_q <= 1'b0;
                            if (is_rd_q) begin
                                rdata_q  <= rsh_q;
                                rd_err_q <= err_q;
                            end
                        end else begin
                            cnt_q   <= cnt_q - CNT_W'(1);
                            mdo_q   <= frame_q[NBITS-1];
                            mdo_t_q <= ~(is_rd_q && (cnt_q <= CNT_TA1_START));
                            frame_q <= frame_q << 1;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                        // MDC rising edge: the PHY's read data is captured here
                        if (div_q == DIV_RISE) begin
                            mdc_q <= 1'b1;
                            if (is_rd_q) begin
                                if (cnt_q == CNT_TA2) begin
                                    err_q <= i_mdi;
                                end
                                if (cnt_q < CNT_DATA) begin
                                    rsh_q <= {rsh_q[14:0], i_mdi};
                                end
                            end
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mdc         = mdc_q;
    assign o_mdo         = mdo_q;
    assign o_mdo_t       = mdo_t_q;
    assign mgmt.o_busy   = busy_q;
    assign mgmt.o_done   = done_q;
    assign mgmt.o_rdata  = rdata_q;
    assign mgmt.o_rd_err = rd_err_q;

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: two instances (CLK_DIV=2/PRE=32 and CLK_DIV=3/PRE=0)
// with a behavioural PHY and a frame-level reference model.
module tb_mdio_master;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mdio_master_if ifa();
    mdio_master_if ifb();
    logic mdc_a, mdo_a, mdot_a, mdi_a;
    logic mdc_b, mdo_b, mdot_b, mdi_b;

    mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .mgmt(ifa.slave),
        .o_mdc(mdc_a), .o_mdo(mdo_a), .o_mdo_t(mdot_a), .i_mdi(mdi_a)
    );
    mdio_master #(.CLK_DIV(3), .PREAMBLE_LEN(0)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .mgmt(ifb.slave),
        .o_mdc(mdc_b), .o_mdo(mdo_b), .o_mdo_t(mdot_b), .i_mdi(mdi_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Captured {MDO, MDO_T} at each MDC rise, per instance
    logic mb_a[$], mo_a[$], mb_b[$], mo_b[$];
    logic mdc_prev_a = 1'b0, mdc_prev_b = 1'b0;
    bit          phy_present[2];
    logic [15:0] phy_data[2];
    logic [15:0] exp_rdata[2];
    logic        exp_err[2];
    logic        exp_b[$], exp_o[$];

    // PHY response for bit index n of the current frame; undriven line is pulled up
    function automatic logic phy_drive(input int pre, input bit is_rd, input int n,
                                       input logic [15:0] d, input bit present);
        if (!present || !is_rd) return 1'b1;
        if (n == pre + 15) return 1'b0;
        if (n >= pre + 16 && n < pre + 32) return d[4'(31 + pre - n)];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (mdc_a === 1'b1 && mdc_prev_a === 1'b0) begin
            mb_a.push_back(mdo_a);
            mo_a.push_back(mdot_a);
            mdi_a = phy_drive(32, mb_a.size() > 35 && mb_a[34] === 1'b1 && mb_a[35] === 1'b0,
                              mb_a.size(), phy_data[0], phy_present[0]);
        end
        mdc_prev_a = mdc_a;
    end

    always @(negedge clk) begin
        if (mdc_b === 1'b1 && mdc_prev_b === 1'b0) begin
            mb_b.push_back(mdo_b);
            mo_b.push_back(mdot_b);
            mdi_b = phy_drive(0, mb_b.size() > 3 && mb_b[2] === 1'b1 && mb_b[3] === 1'b0,
                              mb_b.size(), phy_data[1], phy_present[1]);
        end
        mdc_prev_b = mdc_b;
    end

    function automatic int pre_of(input int w); return (w == 0) ? 32 : 0; endfunction
    function automatic int cd_of(input int w);  return (w == 0) ? 2 : 3;  endfunction
    function automatic logic busy_of(input int w); return (w == 0) ? ifa.o_busy : ifb.o_busy; endfunction
    function automatic logic done_of(input int w); return (w == 0) ? ifa.o_done : ifb.o_done; endfunction
    function automatic logic mdc_of(input int w);  return (w == 0) ? mdc_a : mdc_b; endfunction
    function automatic logic mdo_of(input int w);  return (w == 0) ? mdo_a : mdo_b; endfunction
    function automatic logic mdot_of(input int w); return (w == 0) ? mdot_a : mdot_b; endfunction
    function automatic logic [15:0] rdata_of(input int w); return (w == 0) ? ifa.o_rdata : ifb.o_rdata; endfunction
    function automatic logic rderr_of(input int w); return (w == 0) ? ifa.o_rd_err : ifb.o_rd_err; endfunction
    function automatic int cap_size(input int w); return (w == 0) ? mb_a.size() : mb_b.size(); endfunction
    function automatic logic cap_b(input int w, input int i); return (w == 0) ? mb_a[i] : mb_b[i]; endfunction
    function automatic logic cap_o(input int w, input int i); return (w == 0) ? mo_a[i] : mo_b[i]; endfunction

    function automatic logic [21:0] rstvec_of(input int w);
        return {busy_of(w), done_of(w), rderr_of(w), mdc_of(w), mdo_of(w), mdot_of(w), rdata_of(w)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int w, input bit req, input bit wr, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] d);
        if (w == 0) begin
            ifa.i_req = req; ifa.i_wr = wr; ifa.i_phy_addr = phy; ifa.i_reg_addr = rg; ifa.i_wdata = d;
        end else begin
            ifb.i_req = req; ifb.i_wr = wr; ifb.i_phy_addr = phy; ifb.i_reg_addr = rg; ifb.i_wdata = d;
        end
    endtask

    task automatic set_junk(input int w, input bit req);
        set_req(w, req, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 16'($urandom));
    endtask

    task automatic clear_cap(input int w);
        if (w == 0) begin mb_a.delete(); mo_a.delete(); mdi_a = 1'b1; end
        else begin mb_b.delete(); mo_b.delete(); mdi_b = 1'b1; end
    endtask

    task automatic push(input logic b, input logic o);
        exp_b.push_back(b);
        exp_o.push_back(o);
    endtask

    // Reference frame: what MDO/MDO_T must show at each MDC rise
    task automatic build_expect(input int pre, input bit wr, input logic [4:0] phy,
                                input logic [4:0] rg, input logic [15:0] d);
        exp_b.delete();
        exp_o.delete();
        repeat (pre) push(1'b1, 1'b1);
        push(1'b0, 1'b1); push(1'b1, 1'b1);
        if (wr) begin push(1'b0, 1'b1); push(1'b1, 1'b1); end
        else    begin push(1'b1, 1'b1); push(1'b0, 1'b1); end
        for (int i = 4; i >= 0; i--) push(phy[i], 1'b1);
        for (int i = 4; i >= 0; i--) push(rg[i], 1'b1);
        if (wr) begin
            push(1'b1, 1'b1); push(1'b0, 1'b1);
            for (int i = 15; i >= 0; i--) push(d[i], 1'b1);
        end else begin
            repeat (18) push(1'b1, 1'b0);
        end
    endtask

    task automatic cmp_frame(input int w, input string tag);
        int n, bb, bo;
        n = cap_size(w);
        bb = 0;
        bo = 0;
        chk({tag, " nbits"}, 32'(n), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size(); i++) begin
            if (i >= n || cap_b(w, i) !== exp_b[i]) bb++;
            if (i >= n || cap_o(w, i) !== exp_o[i]) bo++;
        end
        chk({tag, " mdo bad bits"}, 32'(bb), 32'd0);
        chk({tag, " mdo_t bad bits"}, 32'(bo), 32'd0);
    endtask

    task automatic wait_done(input int w, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_of(w) === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic end_checks(input int w, input string tag);
        chk({tag, " rdata"}, 32'(rdata_of(w)), 32'(exp_rdata[w]));
        chk({tag, " rd_err"}, 32'(rderr_of(w)), 32'(exp_err[w]));
        chk({tag, " done pins"}, 32'({busy_of(w), mdc_of(w), mdo_of(w), mdot_of(w)}), 32'h2);
    endtask

    task automatic run_frame(input int w, input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                             input logic [15:0] d, input bit present, input logic [15:0] pdata,
                             input string tag);
        int acc, at, nb;
        nb = pre_of(w) + 32;
        phy_present[w] = present;
        phy_data[w] = pdata;
        build_expect(pre_of(w), wr, phy, rg, d);
        clear_cap(w);
        @(negedge clk);
        set_req(w, 1'b1, wr, phy, rg, d);
        @(negedge clk);
        acc = cyc;
        chk({tag, " accept busy"}, 32'(busy_of(w)), 32'd1);
        set_junk(w, 1'b0);
        wait_done(w, 4 * cd_of(w) * nb, at);
        chk({tag, " latency"}, 32'(at - acc), 32'(1 + 2 * cd_of(w) * nb));
        cmp_frame(w, tag);
        if (!wr) begin
            exp_rdata[w] = present ? pdata : 16'hFFFF;
            exp_err[w] = !present;
        end
        end_checks(w, tag);
        @(negedge clk);
        chk({tag, " done one cycle"}, 32'({done_of(w), busy_of(w)}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, at, nd, nm, nbusy;
        logic [4:0] p1, r1, p2, r2;
        logic [15:0] d1, d2;

        set_req(0, 1'b0, 1'b0, 5'd0, 5'd0, 16'd0);
        set_req(1, 1'b0, 1'b0, 5'd0, 5'd0, 16'd0);
        mdi_a = 1'b1;
        mdi_b = 1'b1;
        exp_rdata[0] = 16'h0; exp_rdata[1] = 16'h0;
        exp_err[0] = 1'b0;    exp_err[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk("reset A", 32'(rstvec_of(0)), 32'(22'b0000_1000_0000_0000_0000_00));
        chk("reset B", 32'(rstvec_of(1)), 32'(22'b0000_1000_0000_0000_0000_00));

        run_frame(0, 1'b1, 5'd5, 5'h1F, 16'hA5C3, 1'b0, 16'h0, "wr_a5c3");
        run_frame(0, 1'b0, 5'd1, 5'd2, 16'h0, 1'b1, 16'h1234, "rd_1234");
        run_frame(0, 1'b0, 5'd1, 5'd2, 16'h0, 1'b0, 16'h0, "rd_nophy");

        for (int i = 0; i < 8; i++) begin
            run_frame(i % 2, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 16'($urandom),
                      $urandom_range(0, 3) != 0, 16'($urandom), $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a write frame
        clear_cap(0);
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom));
        @(negedge clk);
        set_junk(0, 1'b0);
        for (int i = 0; i < 1000 && mb_a.size() < 40; i++) @(negedge clk);
        chk("rst reach bit40", 32'(mb_a.size()), 32'd40);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        exp_rdata[0] = 16'h0;
        exp_err[0] = 1'b0;
        chk("reset midframe", 32'(rstvec_of(0)), 32'(22'b0000_1000_0000_0000_0000_00));
        nd = 0;
        nm = 0;
        repeat (600) begin
            @(negedge clk);
            nd += int'(done_of(0));
            nm += int'(mdc_of(0));
        end
        chk("abandoned no done", 32'(nd), 32'd0);
        chk("idle no mdc", 32'(nm), 32'd0);
        run_frame(0, 1'b0, 5'($urandom), 5'($urandom), 16'h0, 1'b1, 16'($urandom), "after_rst");

        // Request held high across two writes, extra pulses while busy and in DONE
        p1 = 5'($urandom); r1 = 5'($urandom); d1 = 16'($urandom);
        p2 = 5'($urandom); r2 = 5'($urandom); d2 = 16'($urandom);
        phy_present[0] = 1'b0;
        clear_cap(0);
        build_expect(32, 1'b1, p1, r1, d1);
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, p1, r1, d1);
        @(negedge clk);
        acc = cyc;
        chk("b2b accept1", 32'(busy_of(0)), 32'd1);
        set_req(0, 1'b1, 1'b1, p2, r2, d2);
        wait_done(0, 1024, at);
        chk("b2b latency1", 32'(at - acc), 32'd257);
        cmp_frame(0, "b2b frame1");
        end_checks(0, "b2b1");
        clear_cap(0);
        build_expect(32, 1'b1, p2, r2, d2);
        @(negedge clk);
        chk("b2b idle gap", 32'({busy_of(0), done_of(0)}), 32'd0);
        @(negedge clk);
        acc = cyc;
        chk("b2b accept2", 32'(busy_of(0)), 32'd1);
        set_junk(0, 1'b0);
        repeat (3) begin
            repeat ($urandom_range(5, 40)) @(negedge clk);
            set_junk(0, 1'b1);
            @(negedge clk);
            set_junk(0, 1'b0);
        end
        wait_done(0, 1024, at);
        chk("b2b latency2", 32'(at - acc), 32'd257);
        cmp_frame(0, "b2b frame2");
        end_checks(0, "b2b2");
        set_junk(0, 1'b1);
        @(negedge clk);
        set_junk(0, 1'b0);
        nbusy = 0;
        repeat (30) begin
            nbusy += int'(busy_of(0));
            @(negedge clk);
        end
        chk("req in done ignored", 32'(nbusy), 32'd0);

        // Preamble-suppressed instance
        run_frame(1, 1'b0, 5'($urandom), 5'($urandom), 16'h0, 1'b1, 16'($urandom), "b_rd");
        run_frame(1, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 16'h0, "b_wr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
